// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_pkg;

    localparam logic [12:0] TAG_READ_MEM   = 13'h1100;
    localparam int          LINE_BYTES     = 64;
    localparam int          WORDS_PER_LINE = 16;
    localparam int          BEATS_PER_LINE = 8;

    // Controller states: lookup a captured request, or refill its line from the bus.
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        FILL,
        RESPOND
    } icache_state_t;

endpackage

// File: rtl/icache_line_array.sv
// Tag, valid and data storage for the instruction cache.
// Asynchronous read of one 32-bit word plus its line's tag/valid; synchronous
// writes of one 64-bit beat (an even/odd word pair) and of tag+valid.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 52
) (
    input  logic                    clk,
    input  logic                    reset,
    // read port
    input  logic [$clog2(SETS)-1:0] rd_index,
    input  logic [3:0]              rd_word,
    output logic                    rd_valid,
    output logic [TAG_W-1:0]        rd_tag,
    output logic [31:0]             rd_data,
    // write port
    input  logic [$clog2(SETS)-1:0] wr_index,
    input  logic                    wr_pair_en,
    input  logic [2:0]              wr_beat,
    input  logic [63:0]             wr_pair,
    input  logic                    wr_tag_en,
    input  logic [TAG_W-1:0]        wr_tag
);

    logic [63:0]      data_mem [SETS][BEATS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid_q;
    logic [63:0]      rd_pair;

    // Valid bits are the only storage that must come up in a known state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_tag_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Data and tag payload writes.
    // NOTE: the arrays have no reset branch; every entry is guarded by its valid
    // bit, and a reset port on a RAM would prevent mapping it onto memory macros.
    always_ff @(posedge clk) begin
        if (wr_pair_en) begin
            data_mem[wr_index][wr_beat] <= wr_pair;
        end
        if (wr_tag_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    // Each beat holds two words: low half is the even word, high half the odd.
    assign rd_pair  = data_mem[rd_index][rd_word[3:1]];
    assign rd_data  = rd_word[0] ? rd_pair[63:32] : rd_pair[31:0];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache. Serves one 32-bit word per fetch
// request and refills 64-byte lines over the shared bus (8 x 64-bit beats).
module instruction_cache
    import icache_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int SETS           = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    // fetch side
    input  logic                      ic_req,
    input  logic [57:0]               ic_line_addr,
    input  logic [3:0]                ic_word_select,
    output logic                      ic_ack,
    output logic [63:0]               ic_data_out,
    // bus side
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 58 - IDX_W;

    icache_state_t    state_q, state_d;
    logic [57:0]      line_q;
    logic [3:0]       word_q;
    logic [2:0]       beat_q;

    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             hit;
    logic             wr_pair_en;
    logic             wr_tag_en;

    // The response tag carries no information for a single-outstanding reader.
    logic             unused_resptag;
    assign unused_resptag = ^bus_resptag;

    // Everything downstream of the request works from the captured address.
    assign index = line_q[IDX_W-1:0];
    assign tag   = line_q[57:IDX_W];
    assign hit   = rd_valid && (rd_tag == tag);

    icache_line_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_index   (index),
        .rd_word    (word_q),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_index   (index),
        .wr_pair_en (wr_pair_en),
        .wr_beat    (beat_q),
        .wr_pair    (bus_resp),
        .wr_tag_en  (wr_tag_en),
        .wr_tag     (tag)
    );

    // State register, request capture and refill beat counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            line_q  <= '0;
            word_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && ic_req) begin
                line_q <= ic_line_addr;
                word_q <= ic_word_select;
            end
            if (state_q == MISS_REQ && bus_reqack) begin
                beat_q <= '0;
            end else if (state_q == FILL && bus_respcyc) begin
                beat_q <= beat_q + 3'd1;
            end
        end
    end

    // Next-state and control decode, from registered state plus bus handshakes.
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ic_ack      = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        wr_pair_en  = 1'b0;
        wr_tag_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    ic_ack  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = MISS_REQ;
                end
            end
            MISS_REQ: begin
                bus_reqcyc = 1'b1;
                if (bus_reqack) state_d = FILL;
            end
            FILL: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc) begin
                    wr_pair_en = 1'b1;
                    if (beat_q == 3'(BEATS_PER_LINE - 1)) begin
                        wr_tag_en = 1'b1;
                        state_d   = RESPOND;
                    end
                end
            end
            RESPOND: begin
                ic_ack  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ic_data_out = ic_ack ? {32'b0, rd_data} : 64'b0;
    assign bus_req     = bus_reqcyc ? {line_q, 6'b0} : '0;
    assign bus_reqtag  = bus_reqcyc ? BUS_TAG_WIDTH'(TAG_READ_MEM) : '0;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a table of fetch accesses with
// hand-computed data/latency, plus delayed-ack, reset-mid-refill and
// back-to-back sequences.
module tb_instruction_cache;

    logic        clk;
    logic        reset;
    logic        ic_req;
    logic [57:0] ic_line_addr;
    logic [3:0]  ic_word_select;
    logic        ic_ack;
    logic [63:0] ic_data_out;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    int errors = 0;
    int checks = 0;

    instruction_cache #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .SETS           (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ic_req         (ic_req),
        .ic_line_addr   (ic_line_addr),
        .ic_word_select (ic_word_select),
        .ic_ack         (ic_ack),
        .ic_data_out    (ic_data_out),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .bus_respack    (bus_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // One fetch access. Plays the memory side on a miss: acknowledges the bus
    // request after 'delay' cycles (injecting a stray beat while waiting) and
    // returns beat b = {salt+2b+1, salt+2b}. Cycles are counted from the
    // sampling edge to the cycle in which ic_ack is seen.
    task automatic do_access(input logic [57:0] line, input logic [3:0] word,
                             input int delay, input logic [31:0] salt,
                             output logic miss, output logic [31:0] data,
                             output int cycles);
        logic [31:0] lo;
        miss   = 1'b0;
        data   = '0;
        cycles = 0;
        @(negedge clk);
        ic_req         = 1'b1;
        ic_line_addr   = line;
        ic_word_select = word;
        @(posedge clk);
        @(negedge clk);
        cycles = 1;
        if (!ic_ack) begin
            while (!bus_reqcyc && cycles < 4) begin
                @(negedge clk);
                cycles++;
            end
            if (bus_reqcyc) begin
                miss = 1'b1;
                check("bus_req_addr", bus_req, {line, 6'b0});
                check("bus_reqtag", 64'(bus_reqtag), 64'h1100);
                for (int i = 0; i < delay; i++) begin
                    bus_respcyc = (i == 1);
                    bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
                    #1;
                    if (i == 1) check("stray_respack", 64'(bus_respack), 64'h0);
                    @(negedge clk);
                    cycles++;
                    bus_respcyc = 1'b0;
                    check("reqcyc_held", 64'(bus_reqcyc), 64'h1);
                    check("bus_req_held", bus_req, {line, 6'b0});
                end
                bus_reqack = 1'b1;
                @(negedge clk);
                cycles++;
                bus_reqack = 1'b0;
                check("reqcyc_drop", 64'(bus_reqcyc), 64'h0);
                for (int b = 0; b < 8; b++) begin
                    lo          = salt + 32'(2 * b);
                    bus_respcyc = 1'b1;
                    bus_resp    = {lo + 32'd1, lo};
                    #1;
                    if (b == 0) check("fill_respack", 64'(bus_respack), 64'h1);
                    @(negedge clk);
                    cycles++;
                end
                bus_respcyc = 1'b0;
            end
            while (!ic_ack && cycles < 40) begin
                @(negedge clk);
                cycles++;
            end
        end
        check("ack_seen", 64'(ic_ack), 64'h1);
        if (ic_ack) begin
            data = ic_data_out[31:0];
            check("data_upper_zero", {32'b0, ic_data_out[63:32]}, 64'h0);
        end
        ic_req = 1'b0;
        @(negedge clk);
        check("ack_pulse_end", 64'(ic_ack), 64'h0);
        check("idle_reqcyc", 64'(bus_reqcyc), 64'h0);
    endtask

    typedef struct {
        logic [57:0] line;
        logic [3:0]  word;
        int          delay;
        logic [31:0] salt;
        logic        exp_miss;
        logic [31:0] exp_data;
        int          exp_cycles;
    } vec_t;

    vec_t        vecs [12];
    logic        miss;
    logic [31:0] data;
    int          cycles;
    int          ack_count;

    initial begin
        // line, word, reqack delay, fill salt, miss?, data, cycles
        vecs[0]  = '{58'h1,  4'd3,  0, 32'h000, 1'b1, 32'h003, 11}; // cold miss
        vecs[1]  = '{58'h1,  4'd14, 0, 32'h000, 1'b0, 32'h00E, 1};  // hit after fill
        vecs[2]  = '{58'h41, 4'd5,  0, 32'h100, 1'b1, 32'h105, 11}; // conflict miss
        vecs[3]  = '{58'h41, 4'd0,  0, 32'h000, 1'b0, 32'h100, 1};
        vecs[4]  = '{58'h1,  4'd7,  0, 32'h200, 1'b1, 32'h207, 11}; // evicted line misses again
        vecs[5]  = '{58'h2,  4'd15, 0, 32'h300, 1'b1, 32'h30F, 11};
        vecs[6]  = '{58'h1,  4'd1,  0, 32'h000, 1'b0, 32'h201, 1};
        vecs[7]  = '{58'h2,  4'd8,  0, 32'h000, 1'b0, 32'h308, 1};
        vecs[8]  = '{58'h3FF_FFFF_FFFF_FFC1, 4'd9, 0, 32'h400, 1'b1, 32'h409, 11}; // high tag bits
        vecs[9]  = '{58'h1,  4'd2,  0, 32'h500, 1'b1, 32'h502, 11};
        vecs[10] = '{58'h3,  4'd4,  5, 32'h600, 1'b1, 32'h604, 16}; // delayed reqack + stray beat
        vecs[11] = '{58'h3,  4'd4,  0, 32'h000, 1'b0, 32'h604, 1};

        reset          = 1'b0;
        ic_req         = 1'b0;
        ic_line_addr   = '0;
        ic_word_select = '0;
        bus_reqack     = 1'b0;
        bus_respcyc    = 1'b0;
        bus_resp       = '0;
        bus_resptag    = '0;

        // Reset state
        #2;
        check("rst_ic_ack", 64'(ic_ack), 64'h0);
        check("rst_ic_data_out", ic_data_out, 64'h0);
        check("rst_bus_reqcyc", 64'(bus_reqcyc), 64'h0);
        check("rst_bus_req", bus_req, 64'h0);
        check("rst_bus_reqtag", 64'(bus_reqtag), 64'h0);
        check("rst_bus_respack", 64'(bus_respack), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Table-driven accesses
        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i].line, vecs[i].word, vecs[i].delay, vecs[i].salt, miss, data, cycles);
            check($sformatf("vec%0d_miss", i), 64'(miss), 64'(vecs[i].exp_miss));
            check($sformatf("vec%0d_data", i), 64'(data), 64'(vecs[i].exp_data));
            check($sformatf("vec%0d_cycles", i), 64'(cycles), 64'(vecs[i].exp_cycles));
        end

        // Back-to-back: req held high across an ack gives a second lookup
        ack_count = 0;
        @(negedge clk);
        ic_req         = 1'b1;
        ic_line_addr   = 58'h1;
        ic_word_select = 4'd6;
        @(posedge clk);
        @(negedge clk);
        ack_count += int'(ic_ack);
        check("b2b_ack1", 64'(ic_ack), 64'h1);
        check("b2b_data1", ic_data_out, 64'h506);
        ic_line_addr   = 58'h2;
        ic_word_select = 4'd3;
        @(negedge clk);
        ack_count += int'(ic_ack);
        check("b2b_gap", 64'(ic_ack), 64'h0);
        @(negedge clk);
        ack_count += int'(ic_ack);
        check("b2b_ack2", 64'(ic_ack), 64'h1);
        check("b2b_data2", ic_data_out, 64'h303);
        ic_req = 1'b0;
        @(negedge clk);
        ack_count += int'(ic_ack);
        @(negedge clk);
        ack_count += int'(ic_ack);
        check("b2b_ack_count", 64'(ack_count), 64'h2);

        // Reset in the middle of a refill
        @(negedge clk);
        ic_req         = 1'b1;
        ic_line_addr   = 58'h4;
        ic_word_select = 4'd10;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("rmr_reqcyc", 64'(bus_reqcyc), 64'h1);
        bus_reqack = 1'b1;
        @(negedge clk);
        bus_reqack = 1'b0;
        for (int b = 0; b < 5; b++) begin
            bus_respcyc = 1'b1;
            bus_resp    = {32'h700 + 32'(2 * b + 1), 32'h700 + 32'(2 * b)};
            @(negedge clk);
        end
        bus_resp = {32'h70B, 32'h70A};
        #2;
        reset = 1'b0;
        #1;
        check("rmr_ic_ack", 64'(ic_ack), 64'h0);
        check("rmr_ic_data_out", ic_data_out, 64'h0);
        check("rmr_bus_reqcyc", 64'(bus_reqcyc), 64'h0);
        check("rmr_bus_req", bus_req, 64'h0);
        check("rmr_bus_reqtag", 64'(bus_reqtag), 64'h0);
        check("rmr_bus_respack", 64'(bus_respack), 64'h0);
        ic_req      = 1'b0;
        bus_respcyc = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_access(58'h4, 4'd10, 0, 32'h800, miss, data, cycles);
        check("rmr_refetch_miss", 64'(miss), 64'h1);
        check("rmr_refetch_data", 64'(data), 64'h80A);
        check("rmr_refetch_cycles", 64'(cycles), 64'd11);
        do_access(58'h4, 4'd2, 0, 32'h0, miss, data, cycles);
        check("rmr_hit_miss", 64'(miss), 64'h0);
        check("rmr_hit_data", 64'(data), 64'h802);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
